uart_tx_ctrl: RTL

Transmit-side controller for the UART peripheral. It buffers bytes written by the bus-side register block in a small FIFO and sequences the bit-serial transmitter one byte at a time. It drives the transmitter's `tx_reg`/`tx_strt` inputs and watches its `tx_busy` output. It also reports FIFO status, completion pulses and error flags back to the register block.

---
 rtl/uart_tx_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// Transmit-side UART controller: a byte FIFO feeding a bit-serial transmitter
// through a start/busy handshake, with FIFO status, completion pulses and sticky errors.
module uart_tx_ctrl #(
    parameter int FIFO_AW = 4,
    parameter int ACK_TMO = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_en,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               flush,
    input  logic               err_clr,
    input  logic               tx_busy,
    output logic [7:0]         tx_reg,
    output logic               tx_strt,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               ctrl_busy,
    output logic               tx_done,
    output logic               drain_irq,
    output logic               ovf_err,
    output logic               ack_err
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(ACK_TMO + 1);

    // Handshake: tx_strt is a one-cycle request carrying tx_reg; the transmitter
    // acknowledges by raising tx_busy and signals completion by dropping it.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [1:0]         state_q, state_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [7:0]         tx_reg_q, tx_reg_d;
    logic               tx_strt_q, tx_strt_d;
    logic               tx_done_q, tx_done_d;
    logic               drain_q, drain_d;
    logic               ovf_err_q, ovf_err_d;
    logic               ack_err_q, ack_err_d;
    logic               full, empty, push, pop, ovf_ev, ack_ev;

    assign full  = (level_q == (FIFO_AW + 1)'(DEPTH));
    assign empty = (level_q == '0);

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        tx_reg_d  = tx_reg_q;
        tx_strt_d = 1'b0;
        tx_done_d = 1'b0;
        drain_d   = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        ovf_ev    = 1'b0;
        ack_ev    = 1'b0;
        if (!uart_en) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            state_d  = ST_IDLE;
            tmo_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        tx_reg_d  = mem_q[rd_ptr_q];
                        tx_strt_d = 1'b1;
                        tmo_d     = '0;
                        state_d   = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state_d = ST_WAIT_DONE;
                    end else if (tmo_q == TW'(ACK_TMO - 1)) begin
                        ack_ev  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        tx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // A pop in the same cycle frees the slot, so a write at full still lands.
            push   = wr_en && !flush && (!full || pop);
            ovf_ev = wr_en && !flush && full && !pop;
            if (flush) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                level_d  = '0;
            end else begin
                if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (push && !pop)      level_d = level_q + 1'b1;
                else if (pop && !push) level_d = level_q - 1'b1;
            end
            drain_d = tx_done_d && (level_d == '0);
        end
        ovf_err_d = (ovf_err_q && !err_clr) || ovf_ev;
        ack_err_d = (ack_err_q && !err_clr) || ack_ev;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            tx_reg_q  <= 8'h00;
            tx_strt_q <= 1'b0;
            tx_done_q <= 1'b0;
            drain_q   <= 1'b0;
            ovf_err_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            tx_reg_q  <= tx_reg_d;
            tx_strt_q <= tx_strt_d;
            tx_done_q <= tx_done_d;
            drain_q   <= drain_d;
            ovf_err_q <= ovf_err_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign tx_reg     = tx_reg_q;
    assign tx_strt    = tx_strt_q;
    assign fifo_full  = full;
    assign fifo_empty = empty;
    assign fifo_level = level_q;
    assign ctrl_busy  = (state_q != ST_IDLE) || !empty;
    assign tx_done    = tx_done_q;
    assign drain_irq  = drain_q;
    assign ovf_err    = ovf_err_q;
    assign ack_err    = ack_err_q;
endmodule
